clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog.sv | 121 ++++++++++++
 tb/tb_clk_div_prog.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable multi-channel clock divider: each channel emits a square wave and a
// start-of-period tick, with divisor changes deferred to the next period boundary.
`timescale 1ns/1ps

module clk_div_prog #(
    parameter int NCH     = 4,
    parameter int CW      = 20,
    parameter int DIV_RST = 1953
) (
    input  logic            clk_100m,
    input  logic            rst,
    input  logic [NCH-1:0]  en,
    input  logic            sync,
    input  logic            wr_en,
    input  logic [3:0]      wr_ch,
    input  logic [CW-1:0]   wr_div,
    output logic [NCH-1:0]  clk_out,
    output logic [NCH-1:0]  tick
);

    localparam logic [CW-1:0] DIV_INIT = CW'(DIV_RST);
    localparam logic [CW-1:0] DIV_MIN  = CW'(2);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Divisors below 2 cannot produce a high and a low phase, so they are clamped.
    logic [CW-1:0] wr_val;
    assign wr_val = (wr_div < DIV_MIN) ? DIV_MIN : wr_div;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            state_t        state_reg, state_next;
            logic [CW-1:0] cnt_reg,  cnt_next;
            logic [CW-1:0] d_reg,    d_next;
            logic [CW-1:0] pend_reg, pend_next;
            logic [CW-1:0] cnt_inc;
            logic          clk_reg,  clk_next;
            logic          tick_reg, tick_next;
            logic          wr_hit;
            logic          at_end;

            // Out-of-range channel indices never match any channel, so they are dropped.
            assign wr_hit  = wr_en && (wr_ch == 4'(gi));
            assign at_end  = (cnt_reg >= d_reg - ONE);
            assign cnt_inc = at_end ? '0 : cnt_reg + ONE;

            always_comb begin
                pend_next  = wr_hit ? wr_val : pend_reg;
                state_next = state_reg;
                cnt_next   = cnt_reg;
                d_next     = d_reg;
                clk_next   = clk_reg;
                tick_next  = tick_reg;

                case (state_reg)
                    IDLE: begin
                        d_next    = pend_reg;
                        cnt_next  = '0;
                        clk_next  = 1'b0;
                        tick_next = 1'b0;
                        if (en[gi]) begin
                            state_next = RUN;
                            tick_next  = 1'b1;
                            clk_next   = 1'b1;
                        end
                    end
                    RUN: begin
                        if (!en[gi]) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                            clk_next   = 1'b0;
                            tick_next  = 1'b0;
                        end else if (sync) begin
                            cnt_next  = '0;
                            tick_next = 1'b1;
                            clk_next  = 1'b1;
                            d_next    = pend_reg;
                        end else begin
                            // pend_reg is the pre-edge value, so a write on this edge waits a period.
                            cnt_next  = cnt_inc;
                            tick_next = (cnt_inc == '0);
                            clk_next  = (cnt_inc < (d_reg >> 1));
                            if (cnt_inc == '0) begin
                                d_next = pend_reg;
                            end
                        end
                    end
                    default: begin
                        state_next = IDLE;
                    end
                endcase
            end

            always_ff @(posedge clk_100m or posedge rst) begin
                if (rst) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    d_reg     <= DIV_INIT;
                    pend_reg  <= DIV_INIT;
                    clk_reg   <= 1'b0;
                    tick_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    d_reg     <= d_next;
                    pend_reg  <= pend_next;
                    clk_reg   <= clk_next;
                    tick_reg  <= tick_next;
                end
            end

            assign clk_out[gi] = clk_reg;
            assign tick[gi]    = tick_reg;
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: a phase/period model checked every cycle plus
// hand-computed period, duty and tick-timing expectations.
`timescale 1ns/1ps

module tb_clk_div_prog;
    localparam int NCH  = 4;
    localparam int CW   = 20;
    localparam int DIVR = 1953;

    logic           clk_100m = 1'b0;
    logic           rst      = 1'b0;
    logic [NCH-1:0] en       = '0;
    logic           sync     = 1'b0;
    logic           wr_en    = 1'b0;
    logic [3:0]     wr_ch    = '0;
    logic [CW-1:0]  wr_div   = '0;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    clk_div_prog #(.NCH(NCH), .CW(CW), .DIV_RST(DIVR)) dut (
        .clk_100m (clk_100m),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_div   (wr_div),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #5 clk_100m = ~clk_100m;

    always @(posedge clk_100m) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: each channel is a position within a period of length m_d.
    bit m_run [NCH];
    int m_pos [NCH];
    int m_d   [NCH];
    int m_pend[NCH];

    always @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_run[i]  <= 1'b0;
                m_pos[i]  <= 0;
                m_d[i]    <= DIVR;
                m_pend[i] <= DIVR;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!m_run[i]) begin
                    m_d[i]   <= m_pend[i];
                    m_pos[i] <= 0;
                    if (en[i]) m_run[i] <= 1'b1;
                end else if (!en[i]) begin
                    m_run[i] <= 1'b0;
                    m_pos[i] <= 0;
                end else if (sync || (m_pos[i] + 1 >= m_d[i])) begin
                    m_pos[i] <= 0;
                    m_d[i]   <= m_pend[i];
                end else begin
                    m_pos[i] <= m_pos[i] + 1;
                end
            end
            if (wr_en && (int'(wr_ch) < NCH))
                m_pend[wr_ch] <= (int'(wr_div) < 2) ? 2 : int'(wr_div);
        end
    end

    logic [NCH-1:0] exp_tick, exp_clk;

    always @(negedge clk_100m) begin
        for (int i = 0; i < NCH; i++) begin
            exp_tick[i] = m_run[i] && (m_pos[i] == 0);
            exp_clk[i]  = m_run[i] && (m_pos[i] < m_d[i] / 2);
        end
        chk("model_tick", tick, exp_tick);
        chk("model_clk_out", clk_out, exp_clk);
    end

    task automatic wr(input int ch, input int val);
        wr_en  = 1'b1;
        wr_ch  = 4'(ch);
        wr_div = CW'(val);
        @(negedge clk_100m);
        wr_en  = 1'b0;
    endtask

    task automatic wait_tick(input int ch);
        int n;
        n = 0;
        while (!tick[ch] && n < 5000) begin
            @(negedge clk_100m);
            n++;
        end
        chk("wait_tick", tick[ch], 1);
    endtask

    // Called on a tick cycle: counts the cycles and high cycles of that period.
    task automatic measure(input int ch, output int per, output int hi);
        per = 0;
        hi  = 0;
        do begin
            if (clk_out[ch]) hi++;
            per++;
            @(negedge clk_100m);
        end while (!tick[ch] && per < 5000);
    endtask

    int per, hi, t0, n;

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk_100m);
        chk("reset_clk_out", clk_out, 0);
        chk("reset_tick", tick, 0);

        // Default divisor on channel 0
        rst = 1'b0;
        @(negedge clk_100m);
        en = 4'b0001;
        @(negedge clk_100m);
        chk("first_tick_ch0", tick[0], 1);
        measure(0, per, hi);
        chk("default_period", per, 1953);
        chk("default_high", hi, 976);
        chk("idle_channels_quiet", {clk_out[3:1], tick[3:1]}, 0);
        $display("[TB] default divisor: period %0d high %0d", per, hi);

        // Write landing mid-period is deferred to the boundary
        wr(1, 10);
        @(negedge clk_100m);
        en[1] = 1'b1;
        @(negedge clk_100m);
        chk("ch1_start_tick", tick[1], 1);
        t0 = cyc;
        repeat (3) @(negedge clk_100m);
        wr(1, 4);
        wait_tick(1);
        chk("ch1_old_period_kept", cyc - t0, 10);
        measure(1, per, hi);
        chk("ch1_new_period", per, 4);
        chk("ch1_new_high", hi, 2);
        $display("[TB] deferred write: new period %0d high %0d", per, hi);

        // Divisors 1 and 0 clamp to 2
        wr(2, 1);
        @(negedge clk_100m);
        en[2] = 1'b1;
        @(negedge clk_100m);
        for (int k = 0; k < 4; k++) begin
            chk("ch2_clamp_clk", clk_out[2], (k % 2 == 0) ? 1 : 0);
            chk("ch2_clamp_tick", tick[2], (k % 2 == 0) ? 1 : 0);
            @(negedge clk_100m);
        end
        wr(2, 0);
        repeat (3) @(negedge clk_100m);
        wait_tick(2);
        measure(2, per, hi);
        chk("ch2_zero_period", per, 2);
        chk("ch2_zero_high", hi, 1);
        $display("[TB] clamp: period %0d high %0d", per, hi);

        // Sync realigns running channels at different phases
        en[0] = 1'b0;
        en[2] = 1'b0;
        wr(0, 10);
        wr(2, 7);
        @(negedge clk_100m);
        en[0] = 1'b1;
        @(negedge clk_100m);
        chk("ch0_restart_tick", tick[0], 1);
        repeat (3) @(negedge clk_100m);
        en[2] = 1'b1;
        repeat (3) @(negedge clk_100m);
        chk("ch0_phase6_low", clk_out[0], 0);
        chk("ch2_phase2_high", clk_out[2], 1);
        sync = 1'b1;
        @(negedge clk_100m);
        sync = 1'b0;
        chk("sync_ticks", {tick[2], tick[0]}, 2'b11);
        chk("sync_clk_high", {clk_out[2], clk_out[0]}, 2'b11);
        chk("sync_idle_ch3", {clk_out[3], tick[3]}, 0);
        t0 = cyc;
        @(negedge clk_100m);
        wait_tick(2);
        chk("ch2_after_sync", cyc - t0, 7);
        wait_tick(0);
        chk("ch0_after_sync", cyc - t0, 10);
        $display("[TB] sync: ch2 next tick at +7, ch0 at +%0d", cyc - t0);

        // Disable/re-enable and out-of-range write
        en[1] = 1'b0;
        @(negedge clk_100m);
        chk("ch1_disabled", {clk_out[1], tick[1]}, 0);
        en[1] = 1'b1;
        @(negedge clk_100m);
        chk("ch1_reenable_tick", tick[1], 1);
        wr(5, 3);
        wait_tick(1);
        measure(1, per, hi);
        chk("ch1_ignores_ch5_write", per, 4);
        $display("[TB] re-enable: ch1 period %0d", per);

        // Asynchronous reset between edges
        n = 0;
        while (!clk_out[0] && n < 20) begin
            @(negedge clk_100m);
            n++;
        end
        chk("ch0_high_before_reset", clk_out[0], 1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_clk_out", clk_out, 0);
        chk("async_reset_tick", tick, 0);
        en = 4'b1111;
        @(negedge clk_100m);
        rst = 1'b0;
        @(negedge clk_100m);
        chk("post_reset_ticks", tick, 4'b1111);
        measure(0, per, hi);
        chk("post_reset_period", per, 1953);
        chk("post_reset_high", hi, 976);
        $display("[TB] after reset: period %0d high %0d", per, hi);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
